// File: rtl/letter_display_scanner.sv
// Letter history plus digit scanner for a multiplexed seven-segment display.
// Optional LETTER_BLINK_EN blinks the newest letter on digit 0.
module letter_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               letter_valid,
  input  logic [4:0]                         letter_in,
  output logic                               letter_ready,
  input  logic                               clear,
  output logic [4:0]                         decimal_out,
  output logic [NUM_DIGITS-1:0]              digit_en,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    fill_count,
  output logic                               bad_letter
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(NUM_DIGITS+1);
  localparam logic [4:0] BLANK = 5'd31;

  logic [NUM_DIGITS-1:0][4:0] code;
  logic [NUM_DIGITS-1:0]      vld;
  logic                       rdy_q;
  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  logic                       accept, push, drop;
  logic [4:0]                 shown;

  // rdy_q holds off acceptance for the first cycle after reset release
  assign letter_ready = rdy_q & ~clear;
  assign accept       = letter_valid & letter_ready;
  assign push         = accept & (letter_in <= 5'd25);
  assign drop         = accept & (letter_in >  5'd25);

`ifdef LETTER_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (push) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV-1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + 1'b1;
    end
  end

  always_comb begin
    shown = vld[idx] ? code[idx] : BLANK;
    if (idx == '0 && phase) shown = BLANK;
  end
`else
  always_comb shown = vld[idx] ? code[idx] : BLANK;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code        <= '0;
      vld         <= '0;
      fill_count  <= '0;
      rdy_q       <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      digit_en    <= '0;
      decimal_out <= BLANK;
      bad_letter  <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      bad_letter <= drop;

      // scan timing runs freely; clear never disturbs it
      if (cnt == CW'(REFRESH_DIV-1)) begin
        cnt <= '0;
        idx <= (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (clear) begin
        vld        <= '0;
        fill_count <= '0;
      end else if (push) begin
        code <= {code[NUM_DIGITS-2:0], letter_in};
        vld  <= {vld[NUM_DIGITS-2:0], 1'b1};
        if (fill_count != FW'(NUM_DIGITS)) fill_count <= fill_count + 1'b1;
      end

      digit_en    <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
      decimal_out <= shown;
    end
  end
endmodule

// File: tb/tb_letter_display_scanner.sv
// Randomized + directed bench for letter_display_scanner against a queue-based history model.
module tb_letter_display_scanner;
  localparam int N = 4;
  localparam int R = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         letter_valid;
  logic [4:0]   letter_in;
  logic         letter_ready;
  logic         clear;
  logic [4:0]   decimal_out;
  logic [N-1:0] digit_en;
  logic [2:0]   fill_count;
  logic         bad_letter;

  letter_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(8)) dut (
    .clock(clock), .reset(reset), .letter_valid(letter_valid), .letter_in(letter_in),
    .letter_ready(letter_ready), .clear(clear), .decimal_out(decimal_out),
    .digit_en(digit_en), .fill_count(fill_count), .bad_letter(bad_letter)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int hist[$];   // newest letter at index 0
  int edges;     // clock edges since reset release

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, predict from the model, check after the edge.
  task automatic cyc(input bit v, input int l, input bit c);
    int  idx, exp_dec;
    bit  exp_rdy, acc;
    @(negedge clock);
    letter_valid = v;
    letter_in    = 5'(l);
    clear        = c;
    #1;
    exp_rdy = (edges > 0) && !c;
    chk("letter_ready", 32'(letter_ready), 32'(exp_rdy));
    idx     = (edges / R) % N;
    exp_dec = (idx < hist.size()) ? hist[idx] : 31;
    acc     = v && exp_rdy;
    if (c) hist.delete();
    else if (acc && l <= 25) begin
      hist.push_front(l);
      if (hist.size() > N) void'(hist.pop_back());
    end
    @(posedge clock);
    edges++;
    #1;
    chk("digit_en",    32'(digit_en),    32'(1 << idx));
    chk("decimal_out", 32'(decimal_out), 32'(exp_dec));
    chk("fill_count",  32'(fill_count),  32'(hist.size()));
    chk("bad_letter",  32'(bad_letter),  32'(acc && l > 25));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    letter_valid = 1'b0; clear = 1'b0; letter_in = '0;
    #1;
    chk("rst_decimal_out", 32'(decimal_out),  32'd31);
    chk("rst_digit_en",    32'(digit_en),     32'd0);
    chk("rst_letter_ready",32'(letter_ready), 32'd0);
    chk("rst_bad_letter",  32'(bad_letter),   32'd0);
    chk("rst_fill_count",  32'(fill_count),   32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    edges = 0;
    hist.delete();
  endtask

  initial begin
    reset = 1'b1; letter_valid = 1'b0; clear = 1'b0; letter_in = '0;
    do_reset();

    // idle scan: blank digits rotating
    idle(3 * R + 2);

    // H, E, L then a full scan
    cyc(1, 7, 0); cyc(1, 4, 0); cyc(1, 11, 0);
    idle(N * R + 1);

    // saturation
    for (int i = 0; i <= 5; i++) cyc(1, i, 0);
    idle(N * R + 1);

    // out-of-range letter dropped
    cyc(1, 27, 0);
    idle(3);

    // clear wins over a simultaneous letter
    cyc(1, 9, 1);
    idle(N * R + 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int l;
      bit v, c;
      v = ($urandom_range(0, 1) == 1);
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      c = ($urandom_range(0, 24) == 0);
      cyc(v, l, c);
    end

    // reset mid-scan discards history
    cyc(1, 3, 0); cyc(1, 19, 0);
    idle(R + 1);
    do_reset();
    idle(N * R + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
